// File: rtl/branch_resolve_ctrl.sv
// Branch recovery sequencer: in-order prediction queue, mispredict flush/redirect FSM.
// Optional saturating statistics counters are built when BP_STATS_EN is defined.
module branch_resolve_ctrl #(
  parameter int PC_WIDTH     = 22,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_IF_valid,
  input  logic                     i_IF_isbranch,
  input  logic [PC_WIDTH-1:0]      i_IF_pc,
  input  logic                     i_BP_taken,
  input  logic                     i_ALU_isbranch,
  input  logic [PC_WIDTH-1:0]      i_ALU_pc,
  input  logic                     i_ALU_outcome,
  input  logic [PC_WIDTH-1:0]      i_ALU_target,
  output logic                     o_ALU_prediction,
  output logic                     o_stall_fetch,
  output logic                     o_flush,
  output logic                     o_redirect_valid,
  output logic [PC_WIDTH-1:0]      o_redirect_pc,
  output logic [$clog2(DEPTH):0]   o_queue_count,
  output logic                     o_error,
  output logic [15:0]              o_resolved_cnt,
  output logic [15:0]              o_mispredict_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;

  state_t              state, next_state;
  logic [FC_W-1:0]     flush_cnt;
  logic [CNT_W-1:0]    count;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [PC_WIDTH-1:0] pc_mem [DEPTH];
  logic [DEPTH-1:0]    taken_mem;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                error;

  logic is_idle, stall, push_req, pop, empty_err, pc_mismatch, mispredict, do_push;

  always_comb begin
    is_idle     = (state == IDLE);
    stall       = (count == FULL_CNT) || !is_idle;
    push_req    = is_idle && i_IF_valid && i_IF_isbranch && !stall;
    pop         = is_idle && i_ALU_isbranch && (count != '0);
    empty_err   = is_idle && i_ALU_isbranch && (count == '0);
    pc_mismatch = pop && (pc_mem[rd_ptr] != i_ALU_pc);
    mispredict  = pop && ((taken_mem[rd_ptr] != i_ALU_outcome) || pc_mismatch);
    do_push     = push_req && !mispredict;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state       = state;
    o_flush          = 1'b0;
    o_redirect_valid = 1'b0;
    unique case (state)
      IDLE:    if (mispredict) next_state = FLUSH;
      FLUSH: begin
        o_flush          = 1'b1;
        o_redirect_valid = (flush_cnt == FLUSH_LOAD);
        if (flush_cnt == '0) next_state = RECOVER;
      end
      RECOVER: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Queue storage needs no reset: head contents are only observed when count is non-zero.
  always_ff @(posedge i_Clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]    <= i_IF_pc;
      taken_mem[wr_ptr] <= i_BP_taken;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      flush_cnt   <= '0;
      redirect_pc <= '0;
      error       <= 1'b0;
    end else begin
      if (pc_mismatch || empty_err) error <= 1'b1;
      if (mispredict) begin
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        flush_cnt   <= FLUSH_LOAD;
        redirect_pc <= i_ALU_outcome ? i_ALU_target : (i_ALU_pc + PC_WIDTH'(4));
      end else begin
        if (state == FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - FC_W'(1);
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
        if (do_push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !do_push) count <= count - CNT_W'(1);
      end
    end
  end

  assign o_ALU_prediction = (count != '0) && taken_mem[rd_ptr];
  assign o_stall_fetch    = stall;
  assign o_redirect_pc    = redirect_pc;
  assign o_queue_count    = count;
  assign o_error          = error;

`ifdef BP_STATS_EN
  logic [15:0] resolved_cnt, mispredict_cnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      resolved_cnt   <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (pop && resolved_cnt != 16'hFFFF)          resolved_cnt   <= resolved_cnt + 16'd1;
      if (mispredict && mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

  assign o_resolved_cnt   = resolved_cnt;
  assign o_mispredict_cnt = mispredict_cnt;
`else
  assign o_resolved_cnt   = 16'd0;
  assign o_mispredict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl (default parameters).
module tb_branch_resolve_ctrl;

`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_valid, if_isbranch, bp_taken;
  logic [21:0] if_pc;
  logic        alu_isbranch, alu_outcome;
  logic [21:0] alu_pc, alu_target;
  logic        alu_prediction, stall_fetch, flush, redirect_valid, error;
  logic [21:0] redirect_pc;
  logic [2:0]  queue_count;
  logic [15:0] resolved_cnt, mispredict_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolve_ctrl dut (
    .i_Clk(clk), .i_Reset_n(reset_n),
    .i_IF_valid(if_valid), .i_IF_isbranch(if_isbranch), .i_IF_pc(if_pc), .i_BP_taken(bp_taken),
    .i_ALU_isbranch(alu_isbranch), .i_ALU_pc(alu_pc), .i_ALU_outcome(alu_outcome),
    .i_ALU_target(alu_target),
    .o_ALU_prediction(alu_prediction), .o_stall_fetch(stall_fetch), .o_flush(flush),
    .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .o_queue_count(queue_count), .o_error(error),
    .o_resolved_cnt(resolved_cnt), .o_mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic push, input logic [21:0] pc, input logic taken,
                               input logic res, input logic [21:0] rpc, input logic outcome,
                               input logic [21:0] target);
    if_valid     = push;
    if_isbranch  = push;
    if_pc        = pc;
    bp_taken     = taken;
    alu_isbranch = res;
    alu_pc       = rpc;
    alu_outcome  = outcome;
    alu_target   = target;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 1'b0, 22'h0);
  endtask

  task automatic push_one(input logic [21:0] pc, input logic taken);
    applyStimulus(1'b1, pc, taken, 1'b0, 22'h0, 1'b0, 22'h0);
    tick();
    quiet();
  endtask

  task automatic resolve_one(input logic [21:0] pc, input logic outcome, input logic [21:0] target);
    applyStimulus(1'b0, 22'h0, 1'b0, 1'b1, pc, outcome, target);
    tick();
    quiet();
  endtask

  initial begin
    $display("[TB] starting branch_resolve_ctrl bench");
    quiet();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    checkOutput("rst_count",   32'(queue_count), 32'd0);
    checkOutput("rst_stall",   32'(stall_fetch), 32'd0);
    checkOutput("rst_flush",   32'(flush), 32'd0);
    checkOutput("rst_rvalid",  32'(redirect_valid), 32'd0);
    checkOutput("rst_rpc",     32'(redirect_pc), 32'd0);
    checkOutput("rst_pred",    32'(alu_prediction), 32'd0);
    checkOutput("rst_error",   32'(error), 32'd0);
    checkOutput("rst_resolved", 32'(resolved_cnt), 32'd0);
    checkOutput("rst_mispred", 32'(mispredict_cnt), 32'd0);

    // Correct prediction
    push_one(22'h000100, 1'b1);
    checkOutput("ok_count1", 32'(queue_count), 32'd1);
    applyStimulus(1'b0, 22'h0, 1'b0, 1'b1, 22'h000100, 1'b1, 22'h000800);
    checkOutput("ok_pred", 32'(alu_prediction), 32'd1);
    tick();
    quiet();
    checkOutput("ok_flush", 32'(flush), 32'd0);
    checkOutput("ok_count0", 32'(queue_count), 32'd0);
    checkOutput("ok_resolved", 32'(resolved_cnt), STATS ? 32'd1 : 32'd0);

    // Mispredict: predicted taken, actually not taken
    push_one(22'h000200, 1'b1);
    push_one(22'h000204, 1'b0);
    checkOutput("mp_count2", 32'(queue_count), 32'd2);
    resolve_one(22'h000200, 1'b0, 22'h000999);
    checkOutput("mp_flush1", 32'(flush), 32'd1);
    checkOutput("mp_rvalid1", 32'(redirect_valid), 32'd1);
    checkOutput("mp_rpc", 32'(redirect_pc), 32'h000204);
    checkOutput("mp_cleared", 32'(queue_count), 32'd0);
    checkOutput("mp_stall1", 32'(stall_fetch), 32'd1);
    checkOutput("mp_mispred", 32'(mispredict_cnt), STATS ? 32'd1 : 32'd0);
    tick();
    checkOutput("mp_flush2", 32'(flush), 32'd1);
    checkOutput("mp_rvalid2", 32'(redirect_valid), 32'd0);
    checkOutput("mp_stall2", 32'(stall_fetch), 32'd1);
    applyStimulus(1'b1, 22'h000300, 1'b0, 1'b0, 22'h0, 1'b0, 22'h0);
    tick();
    checkOutput("mp_recover_flush", 32'(flush), 32'd0);
    checkOutput("mp_recover_stall", 32'(stall_fetch), 32'd1);
    checkOutput("mp_flush_nopush", 32'(queue_count), 32'd0);
    tick();
    checkOutput("mp_idle_stall", 32'(stall_fetch), 32'd0);
    checkOutput("mp_recover_nopush", 32'(queue_count), 32'd0);
    tick();
    quiet();
    checkOutput("mp_first_push", 32'(queue_count), 32'd1);
    resolve_one(22'h000300, 1'b0, 22'h0);
    checkOutput("mp_drain", 32'(queue_count), 32'd0);
    checkOutput("mp_drain_flush", 32'(flush), 32'd0);

    // Mispredict: predicted not taken, actually taken
    push_one(22'h3FFFFC, 1'b0);
    resolve_one(22'h3FFFFC, 1'b1, 22'h000040);
    checkOutput("tk_rvalid", 32'(redirect_valid), 32'd1);
    checkOutput("tk_rpc", 32'(redirect_pc), 32'h000040);
    tick(); tick(); tick();
    checkOutput("tk_idle", 32'(stall_fetch), 32'd0);
    checkOutput("tk_rpc_hold", 32'(redirect_pc), 32'h000040);

    // Fall-through redirect wraps at the top of the PC space
    push_one(22'h3FFFFC, 1'b1);
    resolve_one(22'h3FFFFC, 1'b0, 22'h000040);
    checkOutput("wrap_rpc", 32'(redirect_pc), 32'h000000);
    tick(); tick(); tick();
    checkOutput("wrap_idle", 32'(stall_fetch), 32'd0);

    // Full queue
    push_one(22'h000010, 1'b1);
    push_one(22'h000014, 1'b0);
    push_one(22'h000018, 1'b1);
    push_one(22'h00001C, 1'b1);
    checkOutput("full_count", 32'(queue_count), 32'd4);
    checkOutput("full_stall", 32'(stall_fetch), 32'd1);
    push_one(22'h000020, 1'b0);
    checkOutput("full_5th_ignored", 32'(queue_count), 32'd4);
    checkOutput("full_pred_head", 32'(alu_prediction), 32'd1);
    resolve_one(22'h000010, 1'b1, 22'h0);
    checkOutput("full_pop_count", 32'(queue_count), 32'd3);
    checkOutput("full_pop_stall", 32'(stall_fetch), 32'd0);
    checkOutput("full_pop_pred", 32'(alu_prediction), 32'd0);
    checkOutput("full_pop_flush", 32'(flush), 32'd0);
    applyStimulus(1'b1, 22'h000020, 1'b0, 1'b1, 22'h000014, 1'b0, 22'h0);
    tick();
    quiet();
    checkOutput("pushpop_count", 32'(queue_count), 32'd3);
    checkOutput("pushpop_pred", 32'(alu_prediction), 32'd1);
    resolve_one(22'h000018, 1'b1, 22'h0);
    resolve_one(22'h00001C, 1'b1, 22'h0);
    checkOutput("drain_pred_last", 32'(alu_prediction), 32'd0);
    resolve_one(22'h000020, 1'b0, 22'h0);
    checkOutput("drain_count", 32'(queue_count), 32'd0);
    checkOutput("drain_flush", 32'(flush), 32'd0);
    checkOutput("stats_resolved", 32'(resolved_cnt), STATS ? 32'd10 : 32'd0);
    checkOutput("stats_mispred", 32'(mispredict_cnt), STATS ? 32'd3 : 32'd0);
    checkOutput("no_error_yet", 32'(error), 32'd0);

    // Resolve against an empty queue
    resolve_one(22'h000700, 1'b1, 22'h0);
    checkOutput("empty_error", 32'(error), 32'd1);
    checkOutput("empty_noflush", 32'(flush), 32'd0);
    checkOutput("empty_nostall", 32'(stall_fetch), 32'd0);
    checkOutput("empty_count", 32'(queue_count), 32'd0);
    tick();
    checkOutput("error_sticky", 32'(error), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("error_cleared", 32'(error), 32'd0);

    // PC mismatch with matching direction still flushes and flags an error
    push_one(22'h000500, 1'b1);
    resolve_one(22'h000504, 1'b1, 22'h000600);
    checkOutput("pcmm_error", 32'(error), 32'd1);
    checkOutput("pcmm_flush", 32'(flush), 32'd1);
    checkOutput("pcmm_rpc", 32'(redirect_pc), 32'h000600);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("rstflush_flush", 32'(flush), 32'd0);
    checkOutput("rstflush_error", 32'(error), 32'd0);
    checkOutput("rstflush_stall", 32'(stall_fetch), 32'd0);
    checkOutput("rstflush_count", 32'(queue_count), 32'd0);
    checkOutput("rstflush_rpc", 32'(redirect_pc), 32'd0);
    push_one(22'h000900, 1'b1);
    checkOutput("post_rst_push", 32'(queue_count), 32'd1);
    checkOutput("post_rst_pred", 32'(alu_prediction), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
